// File: rtl/shift_sequencer.sv
// Purpose : multi-cycle shift controller (SLL/SRL/SRA/ROTL) that drives one
//           32-bit combinational left barrel shifter through one or two passes.
// Latency : 2 edges after accept (single-pass), 3 edges (SRA negative with
//           shamt!=0, ROTL with shamt!=0).
// Backpr. : req_ready high only in IDLE; response held stable in DONE until
//           rsp_ready, then req_ready returns the following cycle.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_op[1:0]                     00 SLL, 01 SRL, 10 SRA, 11 ROTL
//   req_data[31:0], req_shamt[4:0]  operand and shift amount
//   rsp_valid/rsp_ready             response handshake
//   rsp_data[31:0]                  registered result
//   busy                            high whenever not IDLE

module shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op;
    logic [31:0] r_data;
    logic [4:0]  r_shamt;
    logic [31:0] r_acc;
    logic [31:0] w_acc_nxt;

    logic [31:0] w_sh_a;
    logic [4:0]  w_sh_b;
    logic [31:0] w_sh_y;
    logic [31:0] w_sh_y_rev;
    logic [31:0] w_data_rev;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    assign w_data_rev = rev32(r_data);
    assign w_sh_y_rev = rev32(w_sh_y);

    sl u_sl (
        .i_a (w_sh_a),
        .i_b (w_sh_b),
        .o_y (w_sh_y)
    );

    // Right shifts are done as rev(rev(x) << n). In PASS2, ROTL adds the
    // wrapped-around bits (x >> (32-n)); SRA ORs in the sign fill built from
    // ~rev(ones << n), i.e. the top n bits set.
    always_comb begin
        w_sh_a = 32'd0;
        w_sh_b = 5'd0;
        case (r_state)
            S_PASS1: begin
                w_sh_b = r_shamt;
                if (r_op == OP_SRL || r_op == OP_SRA) begin
                    w_sh_a = w_data_rev;
                end else begin
                    w_sh_a = r_data;
                end
            end
            S_PASS2: begin
                if (r_op == OP_ROTL) begin
                    w_sh_a = w_data_rev;
                    w_sh_b = 5'd0 - r_shamt;   // 32 - shamt, shamt is 1..31 here
                end else begin
                    w_sh_a = 32'hFFFF_FFFF;
                    w_sh_b = r_shamt;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_PASS1;
                end
            end
            S_PASS1: begin
                if (r_op == OP_SRL || r_op == OP_SRA) begin
                    w_acc_nxt = w_sh_y_rev;
                end else begin
                    w_acc_nxt = w_sh_y;
                end
                case (r_op)
                    OP_SRA:  w_state_nxt = (r_data[31] && r_shamt != 5'd0) ? S_PASS2 : S_DONE;
                    OP_ROTL: w_state_nxt = (r_shamt != 5'd0) ? S_PASS2 : S_DONE;
                    default: w_state_nxt = S_DONE;
                endcase
            end
            S_PASS2: begin
                if (r_op == OP_ROTL) begin
                    w_acc_nxt = r_acc | w_sh_y_rev;
                end else begin
                    w_acc_nxt = r_acc | ~w_sh_y_rev;
                end
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 2'd0;
            r_data  <= 32'd0;
            r_shamt <= 5'd0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_op    <= req_op;
            r_data  <= req_data;
            r_shamt <= req_shamt;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_data  = r_acc;

endmodule

// Purpose : 32-bit combinational logical left barrel shifter.
// Latency : combinational.
// Backpr. : none.
module sl (
    input  logic [31:0] i_a,
    input  logic [4:0]  i_b,
    output logic [31:0] o_y
);
    assign o_y = i_a << i_b;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller built around a single instance of the team's 32-bit combinational left barrel shifter `sl`. It accepts shift requests over a valid/ready handshake. It implements logical left, logical right, arithmetic right and rotate-left by steering the one left shifter through one or two passes, using bit reversal and masking. Results return on a registered valid/ready response channel. It sits between the ALU control path and the shifter, and is the only user of that shifter instance.

## Interface
- Parameters: none; datapath width is fixed at 32, shift amount at 5 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  2  operation code:
  - 00 SLL
  - 01 SRL
  - 10 SRA
  - 11 ROTL
- req_data  in  32  operand.
- req_shamt  in  5  shift amount, 0..31.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  result; registered.
- busy  out  1  high in every state except IDLE.

## Operation
- Registers:
  - state
  - op_r(2)
  - data_r(32)
  - shamt_r(5)
  - acc(32)
- rev(x) means bit reversal: rev(x)[i] = x[31-i].
- The shifter instance has inputs sh_a(32) and sh_b(5), and output sh_y(32). These are muxed from state and op_r.
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture op/data/shamt into op_r/data_r/shamt_r, then go to PASS1.
- PASS1 (sh_b=shamt_r):
  - SLL, ROTL: sh_a=data_r, acc<=sh_y.
  - SRL, SRA: sh_a=rev(data_r), acc<=rev(sh_y).
  - Next state:
    - SLL, SRL: go to DONE.
    - SRA: go to PASS2 if data_r[31]=1 and shamt_r!=0; else go to DONE.
    - ROTL: go to PASS2 if shamt_r!=0; else go to DONE.
- PASS2 (next state is always DONE):
  - ROTL: sh_a=rev(data_r), sh_b=32-shamt_r. The 5-bit result is valid because shamt_r is in 1..31. acc<=acc | rev(sh_y).
  - SRA: sh_a=32'hFFFF_FFFF, sh_b=shamt_r. acc<=acc | ~rev(sh_y). This ORs in the top shamt_r bits as sign fill.
- DONE:
  - rsp_valid=1, rsp_data=acc.
  - On rsp_ready go to IDLE.
  - req_ready=0; req_valid is ignored and no request is captured.
- The shifter inputs are don't-care in IDLE and DONE. Hold them at zero to limit toggling.
- Reset (async, rst_n low):
  - state=IDLE, acc=0, op_r/data_r/shamt_r=0.
  - rsp_valid=0, rsp_data=0, busy=0, req_ready=1.
- Reset asserted mid-operation aborts the operation. No response is produced, and the next request after release is processed normally.

## Timing
- The request is accepted at edge E0; the block is in PASS1 during the following cycle.
- Single-pass operations assert rsp_valid after E1. These are SLL, SRL, SRA with a positive operand or shamt=0, and ROTL with shamt=0.
- Two-pass operations assert rsp_valid after E2.
- rsp_valid and rsp_data stay stable while rsp_ready=0, for any number of cycles.
- The response is consumed on the edge where rsp_valid&rsp_ready; req_ready rises the cycle after.
- Minimum request spacing is 3 cycles for single-pass operations and 4 for two-pass operations.
- req_ready, rsp_valid and busy are decoded from registered state only. There is no combinational path from req_valid or rsp_ready to any output.

## Test plan
- SLL: req_data=0x0000_0001, shamt=31 -> rsp_data=0x8000_0000, rsp_valid 2 edges after accept. Also shamt=0 -> 0x0000_0001.
- SRL: 0x8000_0000, shamt=4 -> 0x0800_0000 (2 edges).
- SRA:
  - 0x8000_0000, shamt=4 -> 0xF800_0000 (3 edges).
  - 0x7000_0000, shamt=4 -> 0x0700_0000 (2 edges).
  - 0xFFFF_FFF0, shamt=31 -> 0xFFFF_FFFF.
- ROTL:
  - 0x8000_0001, shamt=1 -> 0x0000_0003 (3 edges).
  - 0x1234_5678, shamt=8 -> 0x3456_7812.
  - shamt=0 -> operand unchanged (2 edges).
- Backpressure: hold rsp_ready=0 for 5 cycles while driving a second req_valid -> rsp_data stays stable, req_ready=0, and the second request is not captured. After rsp_ready=1, the second request is accepted the cycle after the response handshake.
- Reset in PASS2 of an SRA: pull rst_n low asynchronously -> rsp_valid=0, busy=0, req_ready=1 immediately. After release, SLL 0x1,1 -> 0x2 with normal latency.
